// File: rtl/cache_pkg.sv
// Shared state encodings and field-width helpers for the cache miss controller.
package cache_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_SELECT = 3'd1;
    localparam state_t S_WB     = 3'd2;
    localparam state_t S_REFILL = 3'd3;
    localparam state_t S_COMMIT = 3'd4;

    function automatic int set_bits(input int num_sets);
        return (num_sets > 1) ? $clog2(num_sets) : 1;
    endfunction

    function automatic int way_bits(input int num_ways);
        return (num_ways > 1) ? $clog2(num_ways) : 1;
    endfunction

    function automatic int word_bits(input int block_size);
        return (block_size > 32) ? $clog2(block_size / 32) : 1;
    endfunction

    // Byte-offset width; the set field starts right above it.
    function automatic int offset_bits(input int block_size);
        return $clog2(block_size / 8);
    endfunction

endpackage

// File: rtl/cache_victim_select.sv
// Rotate replacement: lowest invalid way first, otherwise the rotate pointer.
// ROTATE_PER_SET_EN selects one pointer per set instead of one global pointer.
module cache_victim_select
    import cache_pkg::*;
#(
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 4,
    localparam int SET_BITS = set_bits(NUM_SETS),
    localparam int WAY_BITS = way_bits(NUM_WAYS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_WAYS-1:0] valid_ways,
    input  logic [SET_BITS-1:0] set_idx,
    input  logic                advance,
    output logic [WAY_BITS-1:0] victim_way,
    output logic                all_valid
);

    logic [WAY_BITS-1:0] cur_ptr;

`ifdef ROTATE_PER_SET_EN
    logic [NUM_SETS-1:0][WAY_BITS-1:0] ptr;

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (advance)
            ptr[set_idx] <= ptr[set_idx] + WAY_BITS'(1);
    end

    assign cur_ptr = ptr[set_idx];
`else
    logic [WAY_BITS-1:0] ptr;
    logic                unused_set;

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (advance)
            ptr <= ptr + WAY_BITS'(1);
    end

    assign cur_ptr    = ptr;
    assign unused_set = ^set_idx;
`endif

    assign all_valid = &valid_ways;

    always_comb begin
        logic found;
        found      = 1'b0;
        victim_way = cur_ptr;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (!valid_ways[i] && !found) begin
                victim_way = WAY_BITS'(i);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Miss handler: victim select, dirty writeback, word-wise refill, tag commit.
// Optional macro ROTATE_PER_SET_EN: per-set rotate pointers (default: one global).
module cache_miss_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_SIZE  = 32,
    parameter int NUM_SETS   = 16,
    parameter int NUM_WAYS   = 4,
    parameter int BLOCK_SIZE = 32,
    localparam int WORDS     = BLOCK_SIZE / 32,
    localparam int SET_BITS  = set_bits(NUM_SETS),
    localparam int WAY_BITS  = way_bits(NUM_WAYS),
    localparam int WORD_BITS = word_bits(BLOCK_SIZE),
    localparam int OFF_BITS  = offset_bits(BLOCK_SIZE)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 miss_valid,
    input  logic [ADDR_SIZE-1:0] miss_addr,
    input  logic [NUM_WAYS-1:0]  valid_ways,
    input  logic [NUM_WAYS-1:0]  dirty_ways,
    input  logic [ADDR_SIZE-1:0] victim_addr,
    input  logic [31:0]          victim_rdata,
    output logic [WAY_BITS-1:0]  victim_way,
    output logic [WORD_BITS-1:0] word_idx,
    output logic                 fill_we,
    output logic [31:0]          fill_wdata,
    output logic                 fill_tag_we,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic                 mem_ack,
    input  logic [31:0]          mem_rdata,
    output logic                 miss_done,
    output logic                 busy
);

    state_t                 state;
    logic                   from_ptr;
    logic [WAY_BITS-1:0]    sel_way;
    logic                   sel_all_valid;
    logic                   last_word;
    logic [ADDR_SIZE-1:0]   miss_base;
    logic [ADDR_SIZE-1:0]   xfer_base;

    cache_victim_select #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS)
    ) u_vsel (
        .clk        (clk),
        .rst        (rst),
        .valid_ways (valid_ways),
        .set_idx    (miss_addr[OFF_BITS +: SET_BITS]),
        .advance    (state == S_COMMIT && from_ptr),
        .victim_way (sel_way),
        .all_valid  (sel_all_valid)
    );

    assign last_word = (word_idx == WORD_BITS'(WORDS - 1));
    assign miss_base = {miss_addr[ADDR_SIZE-1:OFF_BITS], OFF_BITS'(0)};
    assign xfer_base = (state == S_WB) ? victim_addr : miss_base;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            victim_way <= '0;
            word_idx   <= '0;
            from_ptr   <= 1'b0;
        end else begin
            case (state)
                S_IDLE:
                    if (miss_valid) state <= S_SELECT;
                S_SELECT: begin
                    victim_way <= sel_way;
                    from_ptr   <= sel_all_valid;
                    word_idx   <= '0;
                    state      <= (valid_ways[sel_way] && dirty_ways[sel_way]) ? S_WB : S_REFILL;
                end
                S_WB:
                    if (mem_ack) begin
                        if (last_word) begin
                            word_idx <= '0;
                            state    <= S_REFILL;
                        end else begin
                            word_idx <= word_idx + WORD_BITS'(1);
                        end
                    end
                // word_idx saturates on the last word; the ack moves the FSM on
                S_REFILL:
                    if (mem_ack) begin
                        if (last_word) state    <= S_COMMIT;
                        else           word_idx <= word_idx + WORD_BITS'(1);
                    end
                S_COMMIT:
                    state <= S_IDLE;
                default:
                    state <= S_IDLE;
            endcase
        end
    end

    assign mem_req     = (state == S_WB) || (state == S_REFILL);
    assign mem_we      = (state == S_WB);
    assign mem_addr    = mem_req ? xfer_base + (ADDR_SIZE'(word_idx) << 2) : '0;
    assign mem_wdata   = victim_rdata;
    assign fill_we     = (state == S_REFILL) && mem_ack;
    assign fill_wdata  = mem_rdata;
    assign fill_tag_we = (state == S_COMMIT);
    assign miss_done   = (state == S_COMMIT);
    assign busy        = (state != S_IDLE);

endmodule
